// File: rtl/multi_debouncer.sv
// multi_debouncer: per-channel synchronise, tick-qualified debounce, clean level plus rise/fall pulses
module multi_debouncer #(
  parameter int              N_CH         = 4,
  parameter int              BOUNCE_TICKS = 10,
  parameter int              SYNC_STAGES  = 2,
  parameter logic [N_CH-1:0] RESET_VALUE  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [N_CH-1:0] bouncy_in,
  output logic [N_CH-1:0] debounced_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_change
);
  localparam int CW = $clog2(BOUNCE_TICKS + 1);
  typedef enum logic {STABLE, MAYBE} state_t;
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
  logic [N_CH-1:0] s, deb_q, deb_d, rise_q, rise_d, fall_q, fall_d;
  logic any_q, any_d;
  state_t state_q [N_CH];
  state_t state_d [N_CH];
  logic [CW-1:0] cnt_q [N_CH];
  logic [CW-1:0] cnt_d [N_CH];
  assign s = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bouncy_in};
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE: if (s[i] != deb_q[i]) begin
          state_d[i] = MAYBE;
          cnt_d[i]   = '0;
        end
        MAYBE: if (s[i] == deb_q[i]) begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end else if (tick && cnt_q[i] == CW'(BOUNCE_TICKS - 1)) begin
          deb_d[i]   = s[i];
          rise_d[i]  = s[i];
          fall_d[i]  = ~s[i];
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end else if (tick) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
    any_d = |(rise_d | fall_d);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      deb_q  <= RESET_VALUE;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end
  assign debounced_out = deb_q;
  assign rise          = rise_q;
  assign fall          = fall_q;
  assign any_change    = any_q;
endmodule
